// File: rtl/noc_pkg.sv
// Shared constants for the NoC router input stage: port codes, flit types, FSM states.
package noc_pkg;

  localparam int COORD_W = 3;

  localparam logic [2:0] PORT_L    = 3'd0;
  localparam logic [2:0] PORT_N    = 3'd1;
  localparam logic [2:0] PORT_E    = 3'd2;
  localparam logic [2:0] PORT_S    = 3'd3;
  localparam logic [2:0] PORT_W    = 3'd4;
  localparam logic [2:0] PORT_NONE = 3'd7;

  typedef enum logic [1:0] {
    FT_BODY   = 2'b00,
    FT_HEAD   = 2'b01,
    FT_TAIL   = 2'b10,
    FT_SINGLE = 2'b11
  } flit_type_e;

  typedef enum logic {
    ST_IDLE,
    ST_ACTIVE
  } state_e;

  // Head and single both carry a destination; tail and single both close a packet.
  function automatic logic starts_packet(input logic [1:0] ftype);
    return (ftype == FT_HEAD) || (ftype == FT_SINGLE);
  endfunction

  function automatic logic ends_packet(input logic [1:0] ftype);
    return (ftype == FT_TAIL) || (ftype == FT_SINGLE);
  endfunction

endpackage

// File: rtl/noc_sync_fifo.sv
// DEPTH x WIDTH synchronous FIFO with occupancy count; read port is combinational
// from the storage registers and returns zero while empty.
module noc_sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic [CW-1:0]    count,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             full_int;
  logic             do_push;
  logic             do_pop;

  assign full_int = (count_reg == CW'(DEPTH));
  assign empty    = (count_reg == '0);
  assign count    = count_reg;
  // Writes while full are discarded here so callers need not gate them.
  assign do_push  = push && !full_int;
  assign do_pop   = pop && !empty;
  assign rd_data  = empty ? '0 : mem[rd_ptr_reg];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Storage needs no reset: the read port masks it to zero whenever empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= wr_data;
  end

endmodule

// File: rtl/noc_input_buffer.sv
// Router input stage: flit FIFO, XY route from the head flit, wormhole FSM.
// Optional malformed-flit drop counter enabled by defining NOC_INBUF_STATS_EN.
module noc_input_buffer
  import noc_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CUR_X = 0,
  parameter int CUR_Y = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       full,
  output logic [7:0] out_data,
  output logic [2:0] request,
  input  logic       grant
`ifdef NOC_INBUF_STATS_EN
  ,
  output logic [7:0] drop_cnt
`endif
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [COORD_W-1:0] MY_X = COORD_W'(CUR_X);
  localparam logic [COORD_W-1:0] MY_Y = COORD_W'(CUR_Y);

  logic [7:0]    head_flit;
  logic [CW-1:0] fifo_count;
  logic          fifo_empty;
  logic          pop;
  state_e        state_reg, state_next;
  logic [2:0]    route_reg, route_next;

  noc_sync_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(8)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push   (in_valid),
    .pop    (pop),
    .wr_data(in_data),
    .rd_data(head_flit),
    .count  (fifo_count),
    .empty  (fifo_empty)
  );

  assign full     = (fifo_count == CW'(DEPTH));
  assign out_data = head_flit;

  // Dimension-ordered routing: resolve X first, then Y.
  function automatic logic [2:0] xy_route(input logic [7:0] flit);
    logic [COORD_W-1:0] dst_x;
    logic [COORD_W-1:0] dst_y;
    dst_x = flit[5:3];
    dst_y = flit[2:0];
    if (dst_x > MY_X)      return PORT_E;
    else if (dst_x < MY_X) return PORT_W;
    else if (dst_y > MY_Y) return PORT_N;
    else if (dst_y < MY_Y) return PORT_S;
    else                   return PORT_L;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= ST_IDLE;
      route_reg <= PORT_NONE;
    end else begin
      state_reg <= state_next;
      route_reg <= route_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    route_next = route_reg;
    pop        = 1'b0;
    request    = PORT_NONE;
    case (state_reg)
      ST_IDLE: begin
        if (!fifo_empty) begin
          if (starts_packet(head_flit[7:6])) begin
            route_next = xy_route(head_flit);
            state_next = ST_ACTIVE;
          end else begin
            pop = 1'b1;
          end
        end
      end
      ST_ACTIVE: begin
        // Mid-packet heads are plain data here; the latched route persists.
        if (!fifo_empty) begin
          request = route_reg;
          if (grant) begin
            pop = 1'b1;
            if (ends_packet(head_flit[7:6])) state_next = ST_IDLE;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

`ifdef NOC_INBUF_STATS_EN
  logic [7:0] drop_cnt_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop_cnt_reg <= 8'h00;
    end else if ((state_reg == ST_IDLE) && pop && (drop_cnt_reg != 8'hFF)) begin
      drop_cnt_reg <= drop_cnt_reg + 8'h01;
    end
  end

  assign drop_cnt = drop_cnt_reg;
`endif

endmodule

// File: tb/tb_noc_input_buffer.sv
// Self-checking bench for noc_input_buffer (CUR=2,2, DEPTH=4): directed packets
// plus random traffic compared against a queue-based packet model.
module tb_noc_input_buffer;

  localparam int DEPTH = 4;
  localparam int CX = 2;
  localparam int CY = 2;

  logic       clk;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       full;
  logic [7:0] out_data;
  logic [2:0] request;
  logic       grant;
`ifdef NOC_INBUF_STATS_EN
  logic [7:0] drop_cnt;
`endif

  noc_input_buffer #(
    .DEPTH(DEPTH),
    .CUR_X(CX),
    .CUR_Y(CY)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .in_data (in_data),
    .in_valid(in_valid),
    .full    (full),
    .out_data(out_data),
    .request (request),
    .grant   (grant)
`ifdef NOC_INBUF_STATS_EN
    ,
    .drop_cnt(drop_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: buffered flits, whether a packet is open, its route, drop count.
  logic [7:0] q[$];
  bit         in_pkt;
  logic [2:0] route;
  int         drops;

  function automatic logic [2:0] ref_route(input logic [7:0] f);
    int dx, dy;
    dx = int'(f[5:3]);
    dy = int'(f[2:0]);
    if (dx > CX) return 3'd2;
    if (dx < CX) return 3'd4;
    if (dy > CY) return 3'd1;
    if (dy < CY) return 3'd3;
    return 3'd0;
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%02h expected=%02h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    in_pkt = 0;
    route  = 3'd7;
    drops  = 0;
  endtask

  // One clock: drive inputs, compare outputs, then advance the model across the edge.
  task automatic step(input bit v, input logic [7:0] d, input bit g);
    int n;
    bit do_push;
    logic [7:0] f;
    logic [2:0] exp_req;
    in_valid = v;
    in_data  = d;
    grant    = g;
    #1;
    n = q.size();
    exp_req = (in_pkt && n > 0) ? route : 3'd7;
    check("request", {5'd0, request}, {5'd0, exp_req});
    check("out_data", out_data, (n > 0) ? q[0] : 8'h00);
    check("full", {7'd0, full}, {7'd0, (n == DEPTH)});
`ifdef NOC_INBUF_STATS_EN
    check("drop_cnt", drop_cnt, 8'(drops));
`endif
    @(posedge clk);
    do_push = v && (n < DEPTH);
    if (n > 0) begin
      if (!in_pkt) begin
        if (q[0][7:6] == 2'b01 || q[0][7:6] == 2'b11) begin
          in_pkt = 1;
          route  = ref_route(q[0]);
        end else begin
          void'(q.pop_front());
          if (drops < 255) drops++;
        end
      end else if (g) begin
        f = q.pop_front();
        if (f[7:6] == 2'b10 || f[7:6] == 2'b11) in_pkt = 0;
      end
    end
    if (do_push) q.push_back(d);
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] rf;
    rst      = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    grant    = 1'b0;
    model_reset();

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_request", {5'd0, request}, 8'h07);
    check("rst_full", {7'd0, full}, 8'h00);
    check("rst_out_data", out_data, 8'h00);
    @(negedge clk);
    rst = 1'b1;
    $display("phase: reset release");

    // Single flit to local port, grant held
    $display("phase: single D2");
    step(1, 8'hD2, 1);
    repeat (3) step(0, 8'h00, 1);

    // Head/body/body/tail eastbound, continuous grant
    $display("phase: packet 62 05 06 87");
    step(1, 8'h62, 1);
    step(1, 8'h05, 1);
    step(1, 8'h06, 1);
    step(1, 8'h87, 1);
    repeat (5) step(0, 8'h00, 1);

    // Overflow: five writes with no grant, the fifth is discarded
    $display("phase: overflow");
    step(1, 8'h61, 0);
    step(1, 8'h01, 0);
    step(1, 8'h02, 0);
    step(1, 8'h83, 0);
    check("full_after_4", {7'd0, full}, 8'h01);
    step(1, 8'h84, 0);
    repeat (6) step(0, 8'h00, 1);

    // Malformed body in IDLE, then southbound head
    $display("phase: malformed 11 then head 50");
    step(1, 8'h11, 0);
    step(0, 8'h00, 0);
    step(1, 8'h50, 0);
    step(0, 8'h00, 0);
    check("south_request", {5'd0, request}, 8'h03);
    step(1, 8'h80, 1);
    repeat (3) step(0, 8'h00, 1);

    // FIFO drained mid-packet, grant pulsed in the gap
    $display("phase: mid-packet gap");
    step(1, 8'h62, 1);
    repeat (3) step(0, 8'h00, 1);
    step(0, 8'h00, 0);
    step(0, 8'h00, 1);
    step(1, 8'h15, 0);
    step(0, 8'h00, 0);
    step(1, 8'h96, 1);
    repeat (3) step(0, 8'h00, 1);

    // Reset asserted mid-packet drops everything
    $display("phase: reset mid-stream");
    step(1, 8'h68, 0);
    step(1, 8'h01, 0);
    step(1, 8'h02, 0);
    rst = 1'b0;
    #1;
    check("midrst_request", {5'd0, request}, 8'h07);
    check("midrst_full", {7'd0, full}, 8'h00);
    check("midrst_out_data", out_data, 8'h00);
`ifdef NOC_INBUF_STATS_EN
    check("midrst_drop_cnt", drop_cnt, 8'h00);
`endif
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    step(0, 8'h00, 0);

    // Random traffic
    $display("phase: random traffic");
    for (int i = 0; i < 800; i++) begin
      rf = 8'($urandom);
      step($urandom_range(0, 3) != 0, rf, $urandom_range(0, 3) != 0);
    end
    repeat (12) step(0, 8'h00, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
